// File: rtl/vga_scan_out.sv
// VGA raster generator: free-running h/v counters, delayed sync/active
// pipeline and a registered, blank-gated RGB output stage.
module vga_scan_out #(
   parameter int   H_ACTIVE   = 800,
   parameter int   H_FP       = 24,
   parameter int   H_SYNC     = 72,
   parameter int   H_BP       = 128,
   parameter int   V_ACTIVE   = 600,
   parameter int   V_FP       = 1,
   parameter int   V_SYNC     = 2,
   parameter int   V_BP       = 22,
   parameter logic HS_POL     = 1'b1,
   parameter logic VS_POL     = 1'b1,
   parameter int   PIPE_DELAY = 1
) (
   input  logic        pixel_clk,
   input  logic        rst,
   input  logic [3:0]  red_in,
   input  logic [3:0]  green_in,
   input  logic [3:0]  blue_in,
   output logic [9:0]  h_coord,
   output logic [9:0]  v_coord,
   output logic        display_on,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   function automatic logic sync_level(input logic asserted, input logic pol);
      return asserted ? pol : ~pol;
   endfunction

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       h_wrap;
   logic       v_wrap;

   assign h_wrap = (h_cnt == H_MAX);
   assign v_wrap = (v_cnt == V_MAX);

   // Counter stage: coordinates are the registers themselves.
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         h_cnt     <= '0;
         v_cnt     <= '0;
         frame_cnt <= '0;
      end else begin
         h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
         if (h_wrap) begin
            v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            if (v_wrap) frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   assign h_coord     = h_cnt;
   assign v_coord     = v_cnt;
   assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

   // Raw timing flags packed as {active, hsync, vsync}.
   logic [2:0] raw_p0;
   logic [2:0] dly;
   logic [10:0] h_ext;
   logic [10:0] v_ext;

   assign h_ext  = {1'b0, h_cnt};
   assign v_ext  = {1'b0, v_cnt};
   assign raw_p0 = {(h_ext < H_VIS) && (v_ext < V_VIS),
                    (h_ext >= HS_START) && (h_ext < HS_END),
                    (v_ext >= VS_START) && (v_ext < VS_END)};

   // Delay stage: matches the external pixel-fetch latency.
   generate
      if (PIPE_DELAY == 0) begin : g_nodly
         assign dly = raw_p0;
      end else begin : g_dly
         logic [2:0] stage_p1 [PIPE_DELAY];
         always_ff @(posedge pixel_clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < PIPE_DELAY; i++) stage_p1[i] <= 3'b000;
            end else begin
               stage_p1[0] <= raw_p0;
               for (int i = 1; i < PIPE_DELAY; i++) stage_p1[i] <= stage_p1[i-1];
            end
         end
         assign dly = stage_p1[PIPE_DELAY-1];
      end
   endgenerate

   // Output stage: colour is forced to black outside the visible area.
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         display_on <= 1'b0;
         vga_hs     <= ~HS_POL;
         vga_vs     <= ~VS_POL;
         vga_r      <= 4'h0;
         vga_g      <= 4'h0;
         vga_b      <= 4'h0;
      end else begin
         display_on <= dly[2];
         vga_hs     <= sync_level(dly[1], HS_POL);
         vga_vs     <= sync_level(dly[0], VS_POL);
         vga_r      <= dly[2] ? red_in   : 4'h0;
         vga_g      <= dly[2] ? green_in : 4'h0;
         vga_b      <= dly[2] ? blue_in  : 4'h0;
      end
   end

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboard bench for vga_scan_out: three instances (small timings with
// delay 1 and 3, inverted polarity, and default timings) share stimulus.
module tb_vga_scan_out;

   localparam int NI   = 3;
   localparam int NCYC = 6000;

   localparam int HA [NI] = '{16, 16, 800};
   localparam int HF [NI] = '{3, 3, 24};
   localparam int HS [NI] = '{5, 5, 72};
   localparam int HB [NI] = '{4, 4, 128};
   localparam int VA [NI] = '{6, 6, 600};
   localparam int VF [NI] = '{2, 2, 1};
   localparam int VS [NI] = '{3, 3, 2};
   localparam int VB [NI] = '{2, 2, 22};
   localparam int PD [NI] = '{1, 3, 1};
   localparam logic HP [NI] = '{1'b1, 1'b0, 1'b1};
   localparam logic VP [NI] = '{1'b1, 1'b0, 1'b1};

   typedef struct { int due; logic de; logic hs; logic vs; logic [3:0] r; logic [3:0] g; logic [3:0] b; } pix_t;
   typedef struct { int due; int h; int v; int fc; logic fs; } crd_t;
   typedef struct { logic act; logic hs; logic vs; } raw_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] ri = 4'h0, gi = 4'h0, bi = 4'h0;

   logic [9:0]  hc [NI];
   logic [9:0]  vc [NI];
   logic        de [NI];
   logic        hs [NI];
   logic        vs [NI];
   logic [3:0]  ro [NI];
   logic [3:0]  go [NI];
   logic [3:0]  bo [NI];
   logic        fs [NI];
   logic [15:0] fc [NI];

   pix_t pq [NI][$];
   crd_t cq [NI][$];
   raw_t hist [NI][$];

   int cyc = -1;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      vga_scan_out #(
         .H_ACTIVE(HA[k]), .H_FP(HF[k]), .H_SYNC(HS[k]), .H_BP(HB[k]),
         .V_ACTIVE(VA[k]), .V_FP(VF[k]), .V_SYNC(VS[k]), .V_BP(VB[k]),
         .HS_POL(HP[k]), .VS_POL(VP[k]), .PIPE_DELAY(PD[k])
      ) dut (
         .pixel_clk(clk), .rst(rst),
         .red_in(ri), .green_in(gi), .blue_in(bi),
         .h_coord(hc[k]), .v_coord(vc[k]),
         .display_on(de[k]), .vga_hs(hs[k]), .vga_vs(vs[k]),
         .vga_r(ro[k]), .vga_g(go[k]), .vga_b(bo[k]),
         .frame_start(fs[k]), .frame_cnt(fc[k])
      );
   end

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, act, exp);
      end
   endtask

   // Reference: position derived from cycles elapsed since reset release.
   function automatic crd_t coord_at(input int k, input int n);
      crd_t c;
      int ht = HA[k] + HF[k] + HS[k] + HB[k];
      int vt = VA[k] + VF[k] + VS[k] + VB[k];
      int pos = n % (ht * vt);
      c.due = 0;
      c.h   = pos % ht;
      c.v   = pos / ht;
      c.fc  = (n / (ht * vt)) % 65536;
      c.fs  = (c.h == 0) && (c.v == 0);
      return c;
   endfunction

   function automatic raw_t raw_of(input int k, input crd_t c);
      raw_t r;
      r.act = (c.h < HA[k]) && (c.v < VA[k]);
      r.hs  = (c.h >= HA[k] + HF[k]) && (c.h < HA[k] + HF[k] + HS[k]);
      r.vs  = (c.v >= VA[k] + VF[k]) && (c.v < VA[k] + VF[k] + VS[k]);
      return r;
   endfunction

   function automatic pix_t pix_of(input int k, input raw_t r, input int due,
                                   input logic [3:0] cr, input logic [3:0] cg, input logic [3:0] cb);
      pix_t p;
      p.due = due;
      p.de  = r.act;
      p.hs  = r.hs ? HP[k] : ~HP[k];
      p.vs  = r.vs ? VP[k] : ~VP[k];
      p.r   = r.act ? cr : 4'h0;
      p.g   = r.act ? cg : 4'h0;
      p.b   = r.act ? cb : 4'h0;
      return p;
   endfunction

   // Stimulus and expectation generation.
   initial begin
      int n;
      logic rst_next;
      raw_t idle;
      crd_t c;
      raw_t r;
      idle = '{act: 1'b0, hs: 1'b0, vs: 1'b0};
      n = 0;
      for (int k = 0; k < NI; k++)
         for (int i = 0; i < PD[k]; i++) hist[k].push_back(idle);
      for (int t = 0; t < NCYC; t++) begin
         @(posedge clk);
         #1;
         cyc = t;
         rst_next = (t < 4) || (t >= 1500 && t < 1503);
         if (t >= 2000 && t < 3500) begin
            ri = 4'hF; gi = 4'hF; bi = 4'hF;
         end else begin
            ri = 4'($urandom); gi = 4'($urandom); bi = 4'($urandom);
         end
         for (int k = 0; k < NI; k++) begin
            if (rst_next) begin
               if (!rst) begin
                  pq[k].delete();
                  pq[k].push_back(pix_of(k, idle, t, ri, gi, bi));
               end
               hist[k].delete();
               for (int i = 0; i < PD[k]; i++) hist[k].push_back(idle);
               hist[k].push_back(idle);
               c = '{due: t, h: 0, v: 0, fc: 0, fs: 1'b1};
            end else begin
               c = coord_at(k, n);
               c.due = t;
               hist[k].push_back(raw_of(k, c));
            end
            cq[k].push_back(c);
            r = hist[k].pop_front();
            pq[k].push_back(pix_of(k, r, t + 1, ri, gi, bi));
         end
         rst = rst_next;
         n = rst_next ? 0 : n + 1;
      end
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Monitor: compare every cycle against the entries due now.
   always @(negedge clk) begin
      crd_t ce;
      pix_t pe;
      for (int k = 0; k < NI; k++) begin
         while (cq[k].size() > 0 && cq[k][0].due <= cyc) begin
            ce = cq[k].pop_front();
            chk("h_coord", k, 32'(hc[k]), 32'(ce.h));
            chk("v_coord", k, 32'(vc[k]), 32'(ce.v));
            chk("frame_start", k, 32'(fs[k]), 32'(ce.fs));
            chk("frame_cnt", k, 32'(fc[k]), 32'(ce.fc));
         end
         while (pq[k].size() > 0 && pq[k][0].due <= cyc) begin
            pe = pq[k].pop_front();
            chk("display_on", k, 32'(de[k]), 32'(pe.de));
            chk("vga_hs", k, 32'(hs[k]), 32'(pe.hs));
            chk("vga_vs", k, 32'(vs[k]), 32'(pe.vs));
            chk("vga_rgb", k, {20'd0, ro[k], go[k], bo[k]}, {20'd0, pe.r, pe.g, pe.b});
         end
      end
   end

endmodule

// File: doc/vga_scan_out.md
VGA_SCAN_OUT -- requirements
Module: vga_scan_out

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
  H_ACTIVE 800, visible pixels per line; H_FP 24, H_SYNC 72, H_BP 128, horizontal front porch, sync and back porch in pixels.
  V_ACTIVE 600, visible lines; V_FP 1, V_SYNC 2, V_BP 22, vertical front porch, sync and back porch in lines.
  HS_POL 1, VS_POL 1, sync active level; PIPE_DELAY 1, cycles from coordinate output to RGB input (0..4).
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
  pixel_clk  in  1  the single clock, 36 MHz pixel clock.
  rst  in  1  reset, asynchronous and active-high.
  red_in/green_in/blue_in  in  4 each  pixel colour for the coordinates presented PIPE_DELAY cycles earlier.
  h_coord/v_coord  out  10 each  current raw scan position, including blanking.
  display_on  out  1  aligned with vga_r/g/b; high while the output pixel is visible.
  vga_hs/vga_vs  out  1 each  sync outputs, aligned with vga_r/g/b.
  vga_r/vga_g/vga_b  out  4 each  registered colour to the DAC.
  frame_start  out  1  one-cycle pulse while h_coord==0 and v_coord==0.
  frame_cnt  out  16  count of completed frames, wraps.

Function
REQ-003 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (1024 by default), and V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (625 by default).
REQ-004 The horizontal counter SHALL increment every pixel_clk cycle and wrap from H_TOTAL-1 to 0.
REQ-005 The vertical counter SHALL increment only in the cycle the horizontal counter wraps, and SHALL wrap from V_TOTAL-1 to 0 when both counters are at their maximum.
REQ-006 h_coord and v_coord SHALL be the counter registers themselves, with zero added latency.
REQ-007 Raw hsync SHALL be true for H_ACTIVE+H_FP <= h <= H_ACTIVE+H_FP+H_SYNC-1 (824..895 by default).
REQ-008 Raw vsync SHALL be true for V_ACTIVE+V_FP <= v <= V_ACTIVE+V_FP+V_SYNC-1 (601..602 by default), evaluated per full line.
REQ-009 Raw active SHALL be (h < H_ACTIVE) and (v < V_ACTIVE).
REQ-010 Raw hsync, vsync and active SHALL pass through a PIPE_DELAY-stage shift register and then one output register.
REQ-011 Total latency from a coordinate appearing on h_coord/v_coord to its sync, display_on and RGB appearing at the outputs SHALL be PIPE_DELAY+1 cycles.
REQ-012 The output register SHALL load vga_r/g/b from red_in/green_in/blue_in when the delayed active is 1, and SHALL load 4'h0 otherwise; RGB is never driven during blanking regardless of the inputs.
REQ-013 vga_hs SHALL equal HS_POL when the delayed hsync is true and ~HS_POL otherwise; vga_vs SHALL follow the same rule with VS_POL.
REQ-014 frame_start SHALL be combinational from the counters, high exactly while h_coord==0 and v_coord==0.
REQ-015 frame_cnt SHALL increment in the cycle both counters wrap, and SHALL wrap from 16'hFFFF to 0.
REQ-016 Parameter values with H_TOTAL > 1024 or V_TOTAL > 1024 are unsupported; the widths SHALL NOT be extended.

Reset
REQ-017 While rst is high, the module SHALL hold: counters 0, all pipeline stages inactive, vga_r/g/b 0, display_on 0, vga_hs ~HS_POL, vga_vs ~VS_POL, frame_cnt 0.
REQ-018 Assertion of rst SHALL take effect without waiting for a pixel_clk edge.
REQ-019 After rst deasserts, the first pixel_clk edge SHALL move h_coord to 1, and scanning SHALL resume from position (0,0) with no partial-frame artefacts in sync.
REQ-020 Reset mid-line or mid-frame SHALL abort the scan and restart at (0,0); frame_cnt SHALL NOT increment for the aborted frame.

Verification
REQ-021 The bench SHALL cover these scenarios (defaults, PIPE_DELAY=1):
  Release reset -> h_coord reads 0,1,2,... and v_coord is 0.
  Release reset -> frame_start is high only in cycle 0.
  h_coord==824 -> vga_hs rises 2 cycles later, is high for exactly 72 cycles, and its period is 1024 cycles.
  Line 601 -> vga_vs is high for exactly 2048 cycles starting 2 cycles after (h=0, v=601).
  frame_cnt reaches 1 after 640000 cycles.
  red_in/green_in/blue_in held at 4'hF -> vga_r/g/b is 4'hF only while display_on is high, giving 800 pixels per line, 600 lines, and 0 in every blanking cycle.
  display_on rises 2 cycles after h_coord==0 on a visible line.
  rst pulsed for 3 cycles at (h=500, v=300) -> outputs go to reset values immediately, and the scan restarts at (0,0) with frame_cnt unchanged.
  Rerun with PIPE_DELAY=3 -> every alignment above shifts to 4 cycles.
